// File: rtl/hwpe_stream_concat_gather_if.sv
// Valid/ready stream bundle: data plus byte strobes, one beat per valid&ready edge.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_concat_gather.sv
// Gathers one beat from every input lane into a single wide output beat,
// lane 0 at the LSBs; each lane is independently one-deep buffered.
module hwpe_stream_concat_gather #(
  parameter int unsigned NB_IN_STREAMS = 2,
  parameter int unsigned DATA_SIZE     = 128,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  hwpe_stream_intf_stream.sink   stream_i [NB_IN_STREAMS-1:0],
  hwpe_stream_intf_stream.source stream_o,
  output logic                   busy_o,
  output logic [CNT_WIDTH-1:0]   cnt_o
);

  localparam int unsigned LANE_SIZE = DATA_SIZE / NB_IN_STREAMS;
  localparam int unsigned LANE_STRB = LANE_SIZE / 8;

  logic [NB_IN_STREAMS-1:0] full;
  logic [DATA_SIZE-1:0]     gathered_data;
  logic [DATA_SIZE/8-1:0]   gathered_strb;
  logic                     out_valid;
  logic                     out_fire;
  logic [CNT_WIDTH-1:0]     cnt_reg;

  assign out_valid = &full;
  assign out_fire  = out_valid & stream_o.ready;

  genvar gi;
  generate
    for (gi = 0; gi < NB_IN_STREAMS; gi++) begin : g_lane
      logic                 full_reg;
      logic [LANE_SIZE-1:0] data_reg;
      logic [LANE_STRB-1:0] strb_reg;
      logic                 capture;

      // A full lane can still accept when the output drains this cycle,
      // which is what sustains one beat per cycle.
      assign stream_i[gi].ready = ~full_reg | out_fire;
      assign capture = stream_i[gi].valid & (~full_reg | out_fire);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          full_reg <= 1'b0;
          data_reg <= '0;
          strb_reg <= '0;
        end else if (clear_i) begin
          full_reg <= 1'b0;
        end else if (capture) begin
          full_reg <= 1'b1;
          data_reg <= stream_i[gi].data;
          strb_reg <= stream_i[gi].strb;
        end else if (out_fire) begin
          full_reg <= 1'b0;
        end
      end

      assign full[gi] = full_reg;
      assign gathered_data[gi*LANE_SIZE +: LANE_SIZE] = data_reg;
      assign gathered_strb[gi*LANE_STRB +: LANE_STRB] = strb_reg;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (clear_i) begin
      cnt_reg <= '0;
    end else if (out_fire) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stream_o.valid = out_valid;
  assign stream_o.data  = gathered_data;
  assign stream_o.strb  = gathered_strb;
  assign busy_o         = |full;
  assign cnt_o          = cnt_reg;

endmodule

// File: tb/tb_hwpe_stream_concat_gather.sv
// Bench for hwpe_stream_concat_gather: scripted lane traffic with a scoreboard
// pairing captured lane beats into expected output beats.
module tb_hwpe_stream_concat_gather;

  localparam int NB = 2;
  localparam int DW = 128;
  localparam int LW = 64;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic oready = 1'b1;
  logic busy;
  logic [CW-1:0] cnt;

  logic [NB-1:0]     lv;
  logic [LW-1:0]     ld [NB];
  logic [LW/8-1:0]   ls [NB];
  logic [NB-1:0]     lr;

  hwpe_stream_intf_stream #(.DATA_WIDTH(LW)) in_s [NB-1:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) out_s ();

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_drv
      assign in_s[gi].valid = lv[gi];
      assign in_s[gi].data  = ld[gi];
      assign in_s[gi].strb  = ls[gi];
      assign lr[gi]         = in_s[gi].ready;
    end
  endgenerate
  assign out_s.ready = oready;

  hwpe_stream_concat_gather #(
    .NB_IN_STREAMS(NB),
    .DATA_SIZE(DW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .clear_i(clear),
    .stream_i(in_s),
    .stream_o(out_s),
    .busy_o(busy),
    .cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: lane beats queue up on handshake; once every lane has one,
  // the concatenation becomes the next expected output beat.
  logic [LW+LW/8-1:0] lq0 [$];
  logic [LW+LW/8-1:0] lq1 [$];
  logic [DW+DW/8-1:0] exp_q [$];
  logic [CW-1:0]      exp_cnt = '0;

  always @(negedge clk) begin
    logic [DW+DW/8-1:0] e;
    logic [LW+LW/8-1:0] a, b;
    if (!rst_n || clear) begin
      lq0.delete();
      lq1.delete();
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      if (out_s.valid && oready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", out_s.data, e[DW-1:0]);
          check("sb_strb", {112'd0, out_s.strb}, {112'd0, e[DW+DW/8-1:DW]});
        end
        check("sb_cnt", {124'd0, cnt}, {124'd0, exp_cnt});
        $display("[TB] beat cnt=%0d data=%h strb=%h", cnt, out_s.data, out_s.strb);
        exp_cnt = exp_cnt + 1'b1;
      end
      if (lv[0] && lr[0]) lq0.push_back({ls[0], ld[0]});
      if (lv[1] && lr[1]) lq1.push_back({ls[1], ld[1]});
      if (lq0.size() > 0 && lq1.size() > 0) begin
        a = lq0.pop_front();
        b = lq1.pop_front();
        exp_q.push_back({b[LW+7:LW], a[LW+7:LW], b[LW-1:0], a[LW-1:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i, input logic v, input logic [LW-1:0] d);
    lv[i] = v;
    ld[i] = d;
    ls[i] = 8'hFF;
  endtask

  task automatic both_random();
    for (int i = 0; i < NB; i++) begin
      lv[i] = 1'b1;
      ld[i] = {$urandom, $urandom};
      ls[i] = 8'($urandom);
    end
  endtask

  initial begin
    lv = '0;
    for (int i = 0; i < NB; i++) begin
      ld[i] = '0;
      ls[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_s.valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", cnt, 0);
    check("rst_data", out_s.data, 0);
    check("rst_strb", out_s.strb, 0);
    check("rst_ready", lr, 2'b11);
    rst_n = 1'b1;

    // Staggered lanes: lane0 at cycle 0, lane1 at cycle 3
    step(); lane(0, 1'b1, 64'hA);
    @(negedge clk); check("a_l0_ready_c0", lr[0], 1); check("a_valid_c0", out_s.valid, 0);
    for (int c = 1; c <= 3; c++) begin
      step(); lane(0, 1'b0, 64'h0);
      if (c == 3) lane(1, 1'b1, 64'hB);
      @(negedge clk);
      check("a_l0_stall", lr[0], 0);
      check("a_valid_early", out_s.valid, 0);
      check("a_busy", busy, 1);
    end
    step(); lane(1, 1'b0, 64'h0);
    @(negedge clk);
    check("a_valid_c4", out_s.valid, 1);
    check("a_data_c4", out_s.data, {64'hB, 64'hA});
    check("a_cnt_c4", cnt, 0);
    step();
    @(negedge clk);
    check("a_cnt_after", cnt, 1);
    check("a_valid_after", out_s.valid, 0);
    check("a_busy_after", busy, 0);

    // Streaming: both lanes valid every cycle
    for (int k = 0; k < 10; k++) begin
      step(); both_random();
      @(negedge clk);
      check("b_no_stall", lr, 2'b11);
      if (k > 0) check("b_valid", out_s.valid, 1);
    end
    step(); lv = '0;
    @(negedge clk); check("b_last_valid", out_s.valid, 1);
    step();
    @(negedge clk);
    check("b_drained", out_s.valid, 0);
    check("b_cnt", cnt, 11);

    // Backpressure: hold output for 5 cycles, then release with new beats
    step(); oready = 1'b0; lane(0, 1'b1, 64'hC0); lane(1, 1'b1, 64'hC1);
    @(negedge clk); check("c_fill_ready", lr, 2'b11);
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      check("c_hold_valid", out_s.valid, 1);
      check("c_hold_data", out_s.data, {64'hC1, 64'hC0});
      check("c_hold_ready", lr, 2'b00);
    end
    step(); oready = 1'b1; lane(0, 1'b1, 64'hD0); lane(1, 1'b1, 64'hD1);
    @(negedge clk);
    check("c_release_ready", lr, 2'b11);
    check("c_release_data", out_s.data, {64'hC1, 64'hC0});
    step(); lv = '0;
    @(negedge clk);
    check("c_next_valid", out_s.valid, 1);
    check("c_next_data", out_s.data, {64'hD1, 64'hD0});
    step();
    @(negedge clk);
    check("c_cnt", cnt, 13);

    // Clear with lane0 full, lane1 empty
    step(); lane(0, 1'b1, 64'hE0);
    step(); lv = '0;
    @(negedge clk); check("d_busy_pre", busy, 1);
    step(); clear = 1'b1;
    step(); clear = 1'b0;
    @(negedge clk);
    check("d_busy_clr", busy, 0);
    check("d_cnt_clr", cnt, 0);
    step(); lane(1, 1'b1, 64'hF1);
    for (int k = 0; k < 3; k++) begin
      step(); lv = '0;
      @(negedge clk); check("d_no_beat", out_s.valid, 0);
    end
    step(); lane(0, 1'b1, 64'hF0);
    step(); lv = '0;
    @(negedge clk);
    check("d_pair_valid", out_s.valid, 1);
    check("d_pair_data", out_s.data, {64'hF1, 64'hF0});
    step();
    @(negedge clk); check("d_cnt", cnt, 1);

    // Counter wrap over 17 beats
    step(); clear = 1'b1;
    step(); clear = 1'b0;
    for (int k = 0; k < 17; k++) begin
      step(); both_random();
    end
    step(); lv = '0;
    step();
    @(negedge clk); check("e_cnt_wrap", cnt, 1);

    // Asynchronous reset mid-gather
    step(); lane(0, 1'b1, 64'h60);
    step(); lv = '0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("r_valid", out_s.valid, 0);
    check("r_busy", busy, 0);
    check("r_cnt", cnt, 0);
    check("r_data", out_s.data, 0);
    check("r_strb", out_s.strb, 0);
    check("r_ready", lr, 2'b11);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(); lane(1, 1'b1, 64'h71);
    step(); lv = '0;
    @(negedge clk); check("r_no_beat", out_s.valid, 0);
    step(); lane(0, 1'b1, 64'h70);
    step(); lv = '0;
    @(negedge clk);
    check("r_pair_valid", out_s.valid, 1);
    check("r_pair_data", out_s.data, {64'h71, 64'h70});
    step();
    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_concat_gather.md
HWPE_STREAM_CONCAT_GATHER -- requirements
Module: hwpe_stream_concat_gather

Interface
REQ-001 The module SHALL take parameter NB_IN_STREAMS, default 2: number of input lanes, legal range 2..16.
REQ-002 The module SHALL take parameter DATA_SIZE, default 128: output data width in bits; LANE_SIZE = DATA_SIZE/NB_IN_STREAMS SHALL be an exact integer multiple of 8.
REQ-003 The module SHALL take parameter CNT_WIDTH, default 16: width of the emitted-beat counter.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port clear_i, input, 1 bit: synchronous clear, active-high.
REQ-007 The module SHALL have port stream_i[NB_IN_STREAMS-1:0], hwpe_stream_intf_stream.sink, LANE_SIZE data and LANE_SIZE/8 strb per lane: input lanes.
REQ-008 The module SHALL have port stream_o, hwpe_stream_intf_stream.source, DATA_SIZE data and DATA_SIZE/8 strb: concatenated output.
REQ-009 The module SHALL have port busy_o, output, 1 bit: at least one lane holds a captured beat.
REQ-010 The module SHALL have port cnt_o, output, CNT_WIDTH bits: number of output beats emitted since reset or clear.

Function
REQ-011 Each lane ii SHALL own one holding register (data, strb) and a full flag full[ii].
REQ-012 Lane handshake: stream_i[ii].ready SHALL be ~full[ii] | out_fire, where out_fire = stream_o.valid & stream_o.ready; ready SHALL NOT depend on stream_i[ii].valid.
REQ-013 Lane capture: when stream_i[ii].valid & stream_i[ii].ready, the lane's data/strb SHALL be registered and full[ii] set at the next edge.
REQ-014 stream_o.valid SHALL be the AND of full[] (registered, no combinational path from any input valid).
REQ-015 stream_o.data SHALL place lane ii at bits [(ii+1)*LANE_SIZE-1 : ii*LANE_SIZE], lane 0 at the LSBs; stream_o.strb SHALL follow the same ordering at LANE_SIZE/8 granularity.
REQ-016 Latency: the output beat SHALL be valid in the cycle after the last missing lane is captured; lanes arriving in the same cycle produce a valid output on the next cycle.
REQ-017 On out_fire, every full[ii] SHALL clear, except lanes capturing in that same cycle, which SHALL remain/become full with the new beat (back-to-back throughput of 1 beat/cycle).
REQ-018 Lanes SHALL be independent: a full lane stalls (ready=0) only until out_fire, regardless of the other lanes' state.
REQ-019 While stream_o.valid=1 and stream_o.ready=0, stream_o.data/strb/valid SHALL remain stable.
REQ-020 cnt_o SHALL increment by 1 on each out_fire and wrap from 2^CNT_WIDTH-1 to 0.
REQ-021 busy_o SHALL be the OR of full[].
REQ-022 clear_i=1 SHALL, at the next edge, clear all full[] and cnt_o; any lane handshake or out_fire in that cycle SHALL be discarded (clear has priority).
REQ-023 Holding registers SHALL NOT be required to reset data/strb beyond what REQ-024 states; output data with valid=0 is don't-care to the consumer.

Reset
REQ-024 On rst_ni=0, asynchronously: full[]=0, cnt_o=0, busy_o=0, stream_o.valid=0, stream_o.data=0, stream_o.strb=0, every stream_i[ii].ready=1.
REQ-025 Reset asserted mid-transaction SHALL drop all partially gathered beats; no output beat SHALL appear after release until all lanes capture anew.

Verification
REQ-026 NB=2, DATA=128: lane0 sends 0xA (64b) at cycle 0, lane1 sends 0xB at cycle 3, out ready=1 -> stream_o.valid at cycle 4, data={0xB,0xA}, cnt_o 0->1; lane0.ready=0 during cycles 1..3.
REQ-027 Both lanes valid every cycle, out ready=1 -> one output beat per cycle after 1-cycle fill, cnt_o increments every cycle, no lane stalls.
REQ-028 Output ready=0 for 5 cycles with all lanes full -> output data/valid stable, all lane readies 0; ready=1 with new lane beats same cycle -> next beat valid the following cycle.
REQ-029 clear_i pulsed while lane0 full, lane1 empty -> busy_o=0 and cnt_o=0 next cycle; subsequent lane1-only beat does not produce output.
REQ-030 CNT_WIDTH=4, 17 output beats -> cnt_o wraps 15->0 and reads 1 at end; async reset mid-gather -> all outputs at REQ-024 values immediately, without waiting for a clock edge.
